// File: rtl/fp_div_pkg.sv
// Shared FP definitions: bias, limits, canonical NaN, FSM states.
// Reused by fp_div and the later FP datapath blocks.
package fp_div_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int MANT_W   = 24;
  localparam int ITERS    = 25;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic infnan;
  } cls_t;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        exc;
  } out_t;

  // Class is decided on the exponent field alone; denormals read as zero.
  function automatic cls_t classify(input logic [7:0] e);
    cls_t c;
    c.zero   = (e == 8'h00);
    c.infnan = (e == 8'hFF);
    return c;
  endfunction

endpackage

// File: rtl/fp_div_if.sv
// Request/response bundle of the FP divider.
// master drives start and operands, slave returns result and flags.
interface fp_div_if;

  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        done;
  logic        busy;
  logic        overflow;
  logic        underflow;
  logic        exception;
  logic [31:0] res;

  modport master (
    output start, op_a, op_b,
    input  done, busy, overflow,
    input  underflow, exception, res
  );

  modport slave (
    input  start, op_a, op_b,
    output done, busy, overflow,
    output underflow, exception, res
  );

endinterface

// File: rtl/fp_mant_div.sv
// Radix-2 restoring mantissa divider, one quotient bit per cycle.
// Produces q = floor(Ma * 2^24 / Mb), MSB first over ITERS cycles.
module fp_mant_div
  import fp_div_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [MANT_W-1:0] ma_i,
  input  logic [MANT_W-1:0] mb_i,
  output logic              done_o,
  output logic [MANT_W:0]   q_o
);

  logic              run_q, run_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [MANT_W+1:0] r_q, r_d;
  logic [MANT_W-1:0] mb_q, mb_d;
  logic [MANT_W:0]   q_q, q_d;
  logic [MANT_W:0]   trial;
  logic [MANT_W:0]   rem;
  logic              ge;
  logic              last;

  assign last = run_q && (cnt_q == 5'(ITERS - 1));

  // R stays below 2*Mb, so bit 25 is clear whenever the trial is kept.
  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    r_d   = r_q;
    mb_d  = mb_q;
    q_d   = q_q;
    ge    = (r_q >= {2'b00, mb_q});
    trial = r_q[MANT_W:0] - {1'b0, mb_q};
    rem   = ge ? trial : r_q[MANT_W:0];
    if (start_i) begin
      run_d = 1'b1;
      cnt_d = '0;
      r_d   = {2'b00, ma_i};
      mb_d  = mb_i;
      q_d   = '0;
    end else if (run_q) begin
      r_d = {rem, 1'b0};
      q_d = {q_q[MANT_W-1:0], ge};
      if (last) begin
        run_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      r_q   <= '0;
      mb_q  <= '0;
      q_q   <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      r_q   <= r_d;
      mb_q  <= mb_d;
      q_q   <= q_d;
    end
  end

  assign done_o = last;
  assign q_o    = q_q;

endmodule

// File: rtl/fp_div.sv
// Iterative IEEE-754 single-precision divider, truncating, fixed latency.
// Owns unpack, special cases, exponent and pack around fp_mant_div.
module fp_div
  import fp_div_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  fp_div_if.slave  bus
);

  localparam logic signed [9:0] EMAX  = 10'(EXP_MAX);
  localparam logic signed [9:0] EBIAS = 10'(EXP_BIAS);

  state_e state_q, state_d;

  logic       sign_q;
  logic [7:0] ea_q, eb_q;
  cls_t       ca_q, cb_q;
  cls_t       ca_in, cb_in;
  out_t       out_q, out_d;
  logic       done_q;

  logic        load;
  logic        fin;
  logic        md_done;
  logic [24:0] q;

  logic signed [9:0] e_raw;
  logic signed [9:0] e_n;
  logic [22:0]       man;

  assign ca_in = classify(bus.op_a[30:23]);
  assign cb_in = classify(bus.op_b[30:23]);

  fp_mant_div u_mant_div (
    .clk     (clk),
    .rst     (rst),
    .start_i (load),
    .ma_i    ({1'b1, bus.op_a[22:0]}),
    .mb_i    ({1'b1, bus.op_b[22:0]}),
    .done_o  (md_done),
    .q_o     (q)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = DIV;
          load    = 1'b1;
        end
      end
      DIV: begin
        if (md_done) state_d = NORM;
      end
      NORM: begin
        state_d = IDLE;
        fin     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0;
      ea_q   <= '0;
      eb_q   <= '0;
      ca_q   <= '0;
      cb_q   <= '0;
    end else if (load) begin
      sign_q <= bus.op_a[31] ^ bus.op_b[31];
      ea_q   <= bus.op_a[30:23];
      eb_q   <= bus.op_b[30:23];
      ca_q   <= ca_in;
      cb_q   <= cb_in;
    end
  end

  // Quotient lies in (0.5, 2): q[24] picks which half, exponent follows.
  assign e_raw = 10'({2'b00, ea_q}) - 10'({2'b00, eb_q}) + EBIAS;
  assign e_n   = q[24] ? e_raw : e_raw - 10'sd1;
  assign man   = q[24] ? q[23:1] : q[22:0];

  always_comb begin
    out_d = '0;
    if (ca_q.infnan || cb_q.infnan || (ca_q.zero && cb_q.zero)) begin
      out_d.res = QNAN;
      out_d.exc = 1'b1;
    end else if (cb_q.zero) begin
      out_d.res = {sign_q, 8'hFF, 23'd0};
      out_d.exc = 1'b1;
    end else if (ca_q.zero) begin
      out_d.res = {sign_q, 31'd0};
    end else if (e_n >= EMAX) begin
      out_d.res = {sign_q, 8'hFF, 23'd0};
      out_d.ovf = 1'b1;
    end else if (e_n <= 10'sd0) begin
      out_d.res = {sign_q, 31'd0};
      out_d.unf = 1'b1;
    end else begin
      out_d.res = {sign_q, e_n[7:0], man};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fin;
      if (fin) out_q <= out_d;
    end
  end

  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.res       = out_q.res;
  assign bus.overflow  = out_q.ovf;
  assign bus.underflow = out_q.unf;
  assign bus.exception = out_q.exc;

endmodule

// File: tb/tb_fp_div.sv
// Scoreboard bench for fp_div: directed corner cases, control-path
// abuse and a random regression against an integer reference model.
module tb_fp_div;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        exc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  exp_t sb[$];
  int   sb_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_div_if bus();

  fp_div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  // Reference: exact integer quotient, truncated, from IEEE field rules.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic        s;
    int          ea, eb, e;
    logic [63:0] ma, mb, qv;
    logic [22:0] man;
    r  = '0;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255 || (ea == 0 && eb == 0)) begin
      r.res = 32'h7FC00000;
      r.exc = 1'b1;
      return r;
    end
    if (eb == 0) begin
      r.res = {s, 8'hFF, 23'd0};
      r.exc = 1'b1;
      return r;
    end
    if (ea == 0) begin
      r.res = {s, 31'd0};
      return r;
    end
    ma = {40'd0, 1'b1, a[22:0]};
    mb = {40'd0, 1'b1, b[22:0]};
    qv = (ma << 24) / mb;
    e  = ea - eb + 127;
    if (qv >= 64'd16777216) begin
      qv  = qv >> 1;
    end else begin
      e = e - 1;
    end
    man = qv[22:0];
    if (e >= 255) begin
      r.res = {s, 8'hFF, 23'd0};
      r.ovf = 1'b1;
    end else if (e <= 0) begin
      r.res = {s, 31'd0};
      r.unf = 1'b1;
    end else begin
      r.res = {s, e[7:0], man};
    end
    return r;
  endfunction

  // Caller is at a negedge; start is sampled by the following posedge.
  task automatic issue_exp(input logic [31:0] a, input logic [31:0] b,
                           input exp_t e);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(e);
    sb_cyc.push_back(cyc);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    issue_exp(a, b, model(a, b));
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got no done, expected %0d pending results",
               sb.size());
      sb.delete();
      sb_cyc.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int   c0;
    if (rst === 1'b0 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)",
                 cyc);
      end else begin
        e  = sb.pop_front();
        c0 = sb_cyc.pop_front();
        chk("res", bus.res, e.res);
        chk("flags", {29'd0, bus.overflow, bus.underflow, bus.exception},
            {29'd0, e.ovf, e.unf, e.exc});
        chk("latency", 32'(cyc - c0), 32'd26);
      end
    end
  end

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_res"}, bus.res, 32'd0);
    chk({tag, "_flags"},
        {29'd0, bus.overflow, bus.underflow, bus.exception}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic [7:0]  xa, xb;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    issue_exp(32'h40C00000, 32'h40000000, exp_t'({32'h40400000, 3'b000}));
    drain();
    issue_exp(32'h3F800000, 32'h40400000, exp_t'({32'h3EAAAAAA, 3'b000}));
    drain();
    issue_exp(32'hBF800000, 32'h00000000, exp_t'({32'hFF800000, 3'b001}));
    drain();
    issue_exp(32'h00000000, 32'h00000000, exp_t'({32'h7FC00000, 3'b001}));
    drain();
    issue_exp(32'h7F000000, 32'h3E800000, exp_t'({32'h7F800000, 3'b100}));
    drain();
    issue_exp(32'h00800000, 32'h40000000, exp_t'({32'h00000000, 3'b010}));
    drain();
    issue_exp(32'h80000000, 32'h40000000, exp_t'({32'h80000000, 3'b000}));
    drain();
    issue_exp(32'h3F800000, 32'h7F800000, exp_t'({32'h7FC00000, 3'b001}));
    drain();

    // Back-to-back: second start lands in the cycle after done.
    issue(32'h40C00000, 32'h40000000);
    repeat (26) @(negedge clk);
    issue(32'hC1200000, 32'h40800000);
    drain();

    // A start five cycles into an operation must be ignored.
    issue_exp(32'h40C00000, 32'h40000000, exp_t'({32'h40400000, 3'b000}));
    repeat (4) @(negedge clk);
    bus.op_a  = 32'h3F800000;
    bus.op_b  = 32'h40400000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (30) @(negedge clk);

    // Reset mid-division aborts the operation with no done.
    bus.op_a  = 32'h3F800000;
    bus.op_b  = 32'h40400000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_idle_zero("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (32) @(negedge clk);
    chk_idle_zero("post_abort");
    issue_exp(32'h40C00000, 32'h40000000, exp_t'({32'h40400000, 3'b000}));
    drain();

    for (int i = 0; i < 40; i++) begin
      xa = (i % 4 == 0) ? 8'($urandom_range(1, 254))
                        : 8'($urandom_range(90, 165));
      xb = (i % 4 == 1) ? 8'($urandom_range(1, 254))
                        : 8'($urandom_range(90, 165));
      a  = {1'($urandom), xa, 23'($urandom)};
      b  = {1'($urandom), xb, 23'($urandom)};
      issue(a, b);
      drain();
    end

    for (int i = 0; i < 8; i++) begin
      xa = (i[0]) ? 8'h00 : 8'($urandom_range(1, 254));
      xb = (i[1]) ? 8'hFF : ((i[2]) ? 8'h00 : 8'($urandom_range(1, 254)));
      a  = {1'($urandom), xa, 23'($urandom)};
      b  = {1'($urandom), xb, 23'($urandom)};
      issue(a, b);
      drain();
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_div.md
FP_DIV -- requirements
Module: fp_div

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Ports SHALL be:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a division; sampled only in IDLE
- done  output  1  single-cycle pulse when res and the flags are valid
- busy  output  1  high while a division is in progress (state not IDLE)
- op_a  input  32  IEEE-754 single-precision dividend
- op_b  input  32  IEEE-754 single-precision divisor
- overflow  output  1  result exponent at or above 255
- underflow  output  1  result exponent at or below 0
- exception  output  1  divide-by-zero, Inf operand or NaN operand
- res  output  32  quotient, packed {sign, exp[7:0], man[22:0]}

Function
REQ-003 States SHALL be IDLE, DIV, NORM.
- IDLE -> DIV on start=1.
- DIV -> NORM when the iteration counter reaches 24.
- NORM -> IDLE unconditionally.
REQ-004 On the start edge, the block SHALL register:
- sign_a ^ sign_b
- mantissas {1, frac}
- ea, eb
- special-case class of both operands
REQ-005 DIV SHALL run radix-2 restoring division for exactly 25 cycles, producing quotient q[24:0] MSB-first.
- Each cycle: remainder R = 2R or 2R - Mb; quotient bit = 1 when the subtraction is non-negative.
- R starts at Ma; width is 26 bits.
REQ-006 The exponent SHALL be computed as a 10-bit signed value, E = ea - eb + 127.
REQ-007 In NORM, normalisation SHALL be:
- q[24]=1: man = q[23:1], exp = E.
- q[24]=0: man = q[22:0], exp = E - 1.
- Truncation only; no rounding.
REQ-008 done SHALL be high for exactly one cycle, at the 26th rising edge after the edge that sampled start.
- Latency SHALL be identical for all operand classes, including special cases.
REQ-009 res and the flags SHALL update only on the done edge and SHALL hold until the next done.
REQ-010 start asserted while busy=1 SHALL be ignored; it is neither queued nor allowed to corrupt the operation in flight.
REQ-011 start may be asserted again in the cycle after done; it is then accepted, giving back-to-back operations every 27 cycles.
REQ-012 Operand classes SHALL be decided on exponent only:
- exp=0: zero (denormals flushed).
- exp=255: Inf/NaN.
REQ-013 Special-case priority, highest first, with no other flags set in each case:
- Either operand exp=255, or both operands zero: res=32'h7FC00000, exception=1.
- op_b zero, op_a finite and nonzero: res = {sign, 8'hFF, 23'd0}, exception=1.
- op_a zero: res = {sign, 31'd0}.
REQ-014 For a normal result path:
- exp >= 255: res = {sign, 8'hFF, 0}, overflow=1.
- exp <= 0: res = {sign, 31'd0}, underflow=1.
REQ-015 overflow, underflow and exception SHALL be mutually exclusive.

Reset
REQ-016 Asserting rst SHALL immediately force the following, including mid-division (the operation is aborted and no done is produced):
- state IDLE
- iteration counter 0
- done=0, busy=0, res=0
- overflow=0, underflow=0, exception=0
REQ-017 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-018 A shared header (fp_defs.vh) SHALL hold:
- EXP_BIAS=127, EXP_MAX=255
- QNAN=32'h7FC00000
- state encodings
fp_mul and later FP blocks SHALL reuse this header.
REQ-019 The iterative mantissa divider SHALL be a sub-module, fp_mant_div, with its own start/done and 24-bit operands; fp_div owns unpack, special cases, exponent handling and pack.
REQ-020 The RTL SHALL contain no combinational "/" operator and no multi-cycle paths.

Verification
REQ-021 op_a=40C00000 (6.0), op_b=40000000 (2.0) -> res=40400000, all flags 0, done exactly 26 edges after start.
REQ-022 op_a=3F800000 (1.0), op_b=40400000 (3.0) -> res=3EAAAAAA (truncated), flags 0.
REQ-023 op_a=BF800000, op_b=00000000 -> res=FF800000, exception=1; then op_a=00000000, op_b=00000000 -> res=7FC00000, exception=1.
REQ-024 op_a=7F000000, op_b=3E800000 -> res=7F800000, overflow=1; op_a=00800000, op_b=40000000 -> res=00000000, underflow=1.
REQ-025 Control-path checks:
- start pulsed at cycle 5 of an operation -> ignored; the original result is unchanged.
- rst asserted at cycle 10 -> no done; outputs 0.
- Subsequent 6.0/2.0 -> 40400000.
REQ-026 A random regression of normal operands SHALL be compared against a truncating reference model, with latency checked on every operation.
